// File: rtl/weight_read_ctrl.sv
// weight_read_ctrl: sequences one neuron's weight-memory reads and pairs each input sample with its weight.
// Latency: a sample accepted in cycle t is presented as a pair in cycle t+2; one pair per cycle sustained.
// Backpressure: out_ready low holds the output register; in_ready drops once p1 and the output are both full.
// Optional build macro WEIGHT_LOAD_EN adds an IDLE-only weight write path towards the memory.
module weight_read_ctrl #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [dataWidth-1:0]  in_data,
  output logic                  in_ready,
  output logic                  mem_ren,
  output logic [addressWidth:0] mem_raddr,
  input  logic [dataWidth-1:0]  mem_wout,
  output logic                  out_valid,
  output logic [dataWidth-1:0]  out_data,
  output logic [dataWidth-1:0]  out_weight,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef WEIGHT_LOAD_EN
  ,
  input  logic                  wr_en,
  input  logic [addressWidth:0] wr_addr,
  input  logic [dataWidth-1:0]  wr_data,
  output logic                  mem_wen,
  output logic [addressWidth:0] mem_waddr,
  output logic [dataWidth-1:0]  mem_win,
  output logic                  wr_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [addressWidth:0] LAST_ADDR = (addressWidth+1)'(numWeight - 1);

  logic [1:0]            state_q, state_d;
  logic [addressWidth:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  p1_valid_q, p1_valid_d;
  logic [dataWidth-1:0]  p1_data_q, p1_data_d;
  logic                  p1_last_q, p1_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [dataWidth-1:0]  out_data_q, out_data_d;
  logic [dataWidth-1:0]  out_weight_q, out_weight_d;
  logic                  out_last_q, out_last_d;

  logic accept;
  logic p1_move;
  logic out_fire;

  // Handshakes: a read is issued only on acceptance, so a stalled p1 keeps mem_wout valid.
  always_comb begin
    in_ready  = (state_q == S_RUN) && !(p1_valid_q && out_valid_q && !out_ready);
    accept    = in_valid && in_ready;
    p1_move   = p1_valid_q && (!out_valid_q || out_ready);
    out_fire  = out_valid_q && out_ready;
    mem_ren   = accept;
    mem_raddr = accept ? cnt_q : '0;
  end

  // Pass sequencing: address counter saturates at the last address; done marks the last handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (cnt_q == LAST_ADDR) state_d = S_DRAIN;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-stage pipe: p1 waits out the memory latency, the output register pairs data with weight.
  always_comb begin
    p1_valid_d   = p1_valid_q;
    p1_data_d    = p1_data_q;
    p1_last_d    = p1_last_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_weight_d = out_weight_q;
    out_last_d   = out_last_q;
    if (p1_move) begin
      out_valid_d  = 1'b1;
      out_data_d   = p1_data_q;
      out_weight_d = mem_wout;
      out_last_d   = p1_last_q;
      p1_valid_d   = 1'b0;
    end else if (out_fire) begin
      out_valid_d  = 1'b0;
    end
    if (accept) begin
      p1_valid_d = 1'b1;
      p1_data_d  = in_data;
      p1_last_d  = (cnt_q == LAST_ADDR);
    end
  end

  // State registers; reset aborts any pass and discards in-flight pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      p1_valid_q   <= 1'b0;
      p1_data_q    <= '0;
      p1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_weight_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      p1_valid_q   <= p1_valid_d;
      p1_data_q    <= p1_data_d;
      p1_last_q    <= p1_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_weight_q <= out_weight_d;
      out_last_q   <= out_last_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_weight = out_weight_q;
  assign out_last   = out_last_q;

`ifdef WEIGHT_LOAD_EN
  logic                  mem_wen_q, mem_wen_d;
  logic [addressWidth:0] mem_waddr_q, mem_waddr_d;
  logic [dataWidth-1:0]  mem_win_q, mem_win_d;
  logic                  wr_err_q, wr_err_d;

  // Loads reach the memory only while idle so they never race a read pass.
  always_comb begin
    mem_wen_d   = wr_en && (state_q == S_IDLE);
    mem_waddr_d = mem_waddr_q;
    mem_win_d   = mem_win_q;
    wr_err_d    = wr_en && (state_q != S_IDLE);
    if (mem_wen_d) begin
      mem_waddr_d = wr_addr;
      mem_win_d   = wr_data;
    end
  end

  // Registered write port towards the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_win_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      mem_win_q   <= mem_win_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign mem_wen   = mem_wen_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_win   = mem_win_q;
  assign wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_weight_read_ctrl.sv
// Bench for weight_read_ctrl with a small pass length, a one-cycle-latency memory model
// and a transaction-level reference model that tracks accepted samples and expected pairs.
module tb_weight_read_ctrl;

  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_ren;
  logic [AW:0]   mem_raddr;
  logic [DW-1:0] mem_wout = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_weight;
  logic          out_last;
  logic          out_ready;
`ifdef WEIGHT_LOAD_EN
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_wen;
  logic [AW:0]   mem_waddr;
  logic [DW-1:0] mem_win;
  logic          wr_err;
`endif

  weight_read_ctrl #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wout(mem_wout),
    .out_valid(out_valid), .out_data(out_data), .out_weight(out_weight),
    .out_last(out_last), .out_ready(out_ready)
`ifdef WEIGHT_LOAD_EN
    ,
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_win(mem_win), .wr_err(wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: one-cycle read latency, data held while no read is issued.
  logic [DW-1:0] mem_arr [0:2047];
  logic [DW-1:0] ref_w   [0:2047];
  logic          tb_load;
  logic [AW:0]   tb_addr;
  logic [DW-1:0] tb_wdata;

  always @(posedge clk) begin
    if (mem_ren) mem_wout <= mem_arr[mem_raddr];
    if (tb_load) mem_arr[tb_addr] <= tb_wdata;
`ifdef WEIGHT_LOAD_EN
    if (mem_wen) mem_arr[mem_waddr] <= mem_win;
`endif
  end

  // Reference model: a pass accepts NW samples, each becomes a pair two cycles later at the
  // earliest; at most two pairs are held, and done follows the last handshake by one cycle.
  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    logic          last;
    int            t;
  } item_t;

  item_t q[$];
  item_t m_it;
  int    cyc = 0;
  int    acc = 0;
  logic  mb = 1'b0;
  logic  done_e = 1'b0;
  logic  m_rdy, m_acc, m_ov, m_start;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      acc    = 0;
      mb     = 1'b0;
      done_e = 1'b0;
    end else begin
      m_start = !mb && start;
      m_rdy   = mb && (acc < NW) && !(q.size() >= 2 && !out_ready);
      m_acc   = in_valid && m_rdy;
      m_ov    = (q.size() > 0) && (q[0].t <= cyc);
      chk("busy", 32'(busy), 32'(mb));
      chk("done", 32'(done), 32'(done_e));
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("mem_ren", 32'(mem_ren), 32'(m_acc));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      done_e = 1'b0;
      if (m_ov) begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("out_weight", 32'(out_weight), 32'(q[0].w));
        chk("out_last", 32'(out_last), 32'(q[0].last));
        if (out_ready) begin
          if (q[0].last) begin
            mb     = 1'b0;
            done_e = 1'b1;
          end
          void'(q.pop_front());
        end
      end
      if (m_acc) begin
        chk("mem_raddr", 32'(mem_raddr), 32'(acc));
        m_it.d    = in_data;
        m_it.w    = ref_w[acc];
        m_it.last = (acc == NW - 1);
        m_it.t    = cyc + 2;
        q.push_back(m_it);
        acc++;
      end
      if (m_start) begin
        mb  = 1'b1;
        acc = 0;
      end
    end
  end

  // Stimulus helpers; each is entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    tb_load  = 1'b1;
    tb_addr  = (AW+1)'(a);
    tb_wdata = v;
    ref_w[a] = v;
    step();
    tb_load  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      step();
      if (ok) break;
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
    chk({tag, "_mem_raddr"}, 32'(mem_raddr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_weight"}, 32'(out_weight), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
`ifdef WEIGHT_LOAD_EN
    chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    chk({tag, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({tag, "_mem_win"}, 32'(mem_win), 32'd0);
    chk({tag, "_wr_err"}, 32'(wr_err), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tb_load = 1'b0; tb_addr = '0; tb_wdata = '0;
`ifdef WEIGHT_LOAD_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    idle(3);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    for (int i = 0; i < NW; i++) preload(i, DW'(16'h0011 * (i + 1)));

    // Back-to-back pass with the output always ready.
    do_start();
    for (int i = 1; i <= NW; i++) send(DW'(i));
    wait_done();
    idle(2);

    // Output stalled for five cycles after the first pair appears.
    out_ready = 1'b0;
    do_start();
    fork
      begin
        for (int i = 1; i <= NW; i++) send(DW'(16'h0100 + i));
      end
      begin
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) ok = 1'b1;
          step();
          if (ok) break;
        end
        chk("stall_first_valid", 32'(ok), 32'd1);
        idle(4);
        out_ready = 1'b1;
      end
    join
    wait_done();
    idle(2);

    // Gapped input: one cycle valid, two idle.
    do_start();
    for (int i = 1; i <= NW; i++) begin
      send(DW'(16'h0200 + i));
      idle(2);
    end
    wait_done();
    idle(2);

    // Samples offered while idle and a start pulse mid-pass are both ignored.
    in_valid = 1'b1;
    in_data  = 16'hdead;
    idle(3);
    in_valid = 1'b0;
    do_start();
    send(16'h0301);
    send(16'h0302);
    do_start();
    send(16'h0303);
    send(16'h0304);
    wait_done();
    idle(2);

    // Reset after the second acceptance, then a fresh pass from address 0.
    do_start();
    send(16'h0401);
    send(16'h0402);
    rst = 1'b1;
    check_reset_outputs("midreset");
    step();
    rst = 1'b0;
    do_start();
    for (int i = 1; i <= NW; i++) send(DW'(16'h0500 + i));
    wait_done();
    idle(2);

`ifdef WEIGHT_LOAD_EN
    // Weight load in IDLE reaches the memory one cycle later and is used by the next pass.
    wr_en = 1'b1; wr_addr = (AW+1)'(2); wr_data = 16'h00aa;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("load_mem_wen", 32'(mem_wen), 32'd1);
    chk("load_mem_waddr", 32'(mem_waddr), 32'd2);
    chk("load_mem_win", 32'(mem_win), 32'h00aa);
    chk("load_wr_err", 32'(wr_err), 32'd0);
    ref_w[2] = 16'h00aa;
    step();
    do_start();
    // A load during a pass is dropped and flagged for one cycle.
    wr_en = 1'b1; wr_addr = (AW+1)'(1); wr_data = 16'h0055;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("run_wr_err", 32'(wr_err), 32'd1);
    chk("run_mem_wen", 32'(mem_wen), 32'd0);
    step();
    @(negedge clk);
    chk("run_wr_err_clear", 32'(wr_err), 32'd0);
    chk("run_mem_wen_clear", 32'(mem_wen), 32'd0);
    step();
    for (int i = 1; i <= NW; i++) send(DW'(16'h0600 + i));
    wait_done();
    idle(2);
`endif

    // Randomised passes: random weights, data, input gaps, output backpressure and stray starts.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NW; i++) preload(i, DW'($urandom));
      do_start();
      fork
        begin
          for (int i = 0; i < NW; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) do_start();
            send(DW'($urandom));
            idle($urandom_range(0, 2));
          end
        end
        begin
          ok = 1'b0;
          for (int k = 0; k < 300; k++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (done) ok = 1'b1;
            step();
            if (ok) break;
          end
          out_ready = 1'b1;
          chk("rand_done_seen", 32'(ok), 32'd1);
        end
      join
      idle($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_read_ctrl.md
# weight_read_ctrl

Sequencer for one neuron's weight memory in the ELM layer datapath. After a `start` pulse it accepts exactly `numWeight` input samples, issues one weight-memory read per accepted sample at consecutive addresses, and absorbs the memory's one-cycle read latency. It emits each input paired with its weight to the neuron MAC, with backpressure, and pulses `done` when the pass drains. One instance sits between the layer input broadcast and each `Weight_Memory_<layer>_<neuron>` instance.

## Interface
- `numWeight`, 784: weights per neuron pass; 1 ≤ `numWeight` ≤ 2**`addressWidth`.
- `addressWidth`, 10: memory depth exponent; the address port is `addressWidth+1` bits wide.
- `dataWidth`, 16: sample and weight width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a pass; honoured only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  single-cycle pulse when the pass completes.
- `in_valid`  in  1  input sample valid.
- `in_data`  in  `dataWidth`  input sample.
- `in_ready`  out  1  controller accepts a sample.
- `mem_ren`  out  1  memory read enable.
- `mem_raddr`  out  `addressWidth+1`  memory read address.
- `mem_wout`  in  `dataWidth`  memory read data; valid the cycle after `mem_ren`, held while `mem_ren`=0.
- `out_valid`  out  1  pair valid.
- `out_data`  out  `dataWidth`  sample.
- `out_weight`  out  `dataWidth`  matching weight.
- `out_last`  out  1  marks the pair for address `numWeight-1`.
- `out_ready`  in  1  downstream accepts the pair.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN on `start`. This clears the address counter `cnt` to 0.
  - RUN → DRAIN on acceptance of the sample with `cnt`=`numWeight-1`.
  - DRAIN → IDLE on the handshake of the `out_last` pair. `done`=1 in that same cycle (registered, so it appears the following cycle).
  - `start` outside IDLE is ignored.
- Acceptance is `in_valid && in_ready`.
  - `in_ready` = (state==RUN) && !(p1_valid && out_valid && !out_ready).
- On acceptance:
  - `mem_ren`=1 and `mem_raddr`=`cnt`, both combinational in that cycle.
  - `in_data` is registered into stage p1 with a last flag; `p1_valid` is set.
  - `cnt` increments.
  - `mem_ren`=0 whenever there is no acceptance.
- Stage p1 moves to the output register when `!out_valid || out_ready`.
  - `out_weight` is loaded from `mem_wout`, `out_data` from p1, and `out_last` from the p1 last flag.
  - A stalled p1 issues no read, so `mem_wout` stays valid.
- `cnt` never exceeds `numWeight-1`, and reads never wrap within a pass. The next pass restarts at 0.
- The output register holds `out_data`, `out_weight` and `out_last` stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, `p1_valid`=0.
  - `busy`=0, `done`=0, `in_ready`=0, `mem_ren`=0, `mem_raddr`=0.
  - `out_valid`=0, `out_data`=0, `out_weight`=0, `out_last`=0.
- `busy` rises the cycle after `start`.
- Latency: a sample accepted in cycle t appears as `out_valid` in cycle t+2 if there is no stall.
- Throughput is one pair per cycle with `out_ready` held high.
- `in_ready` drops in the same cycle that p1 and the output register are both full and `out_ready`=0.
- `done` goes high one cycle after the final handshake. `busy` falls in that same cycle.
- `rst` asserted mid-pass aborts immediately to the reset values. No `done` is produced and any in-flight pair is discarded.

## Configuration
- `WEIGHT_LOAD_EN` defined adds a weight load path:
  - New ports: `wr_en` (in, 1), `wr_addr` (in, `addressWidth+1`), `wr_data` (in, `dataWidth`).
  - New outputs to the memory: `mem_wen`, `mem_waddr`, `mem_win`. These are registered copies of the load path, so writes happen 1 cycle after `wr_en`.
  - Writes are forwarded only in IDLE.
  - `wr_en` outside IDLE is dropped, and `wr_err` (out, 1) pulses for one cycle.
  - `start` in the same cycle as `wr_en` in IDLE: the write is forwarded and the pass starts.
  - All added outputs reset to 0.
- `WEIGHT_LOAD_EN` undefined: none of these ports exist, and the memory is treated as ROM preloaded by its image.

## Test plan
- `numWeight`=4, memory holds 0x0011, 0x0022, 0x0033, 0x0044; `start`, then samples 1–4 back-to-back with `out_ready`=1 → `mem_raddr` reads 0,1,2,3; pairs (1,0x11)…(4,0x44) appear at t+2; `out_last` is set only on the 4th; `done` pulses once, 1 cycle after the 4th handshake.
- Same pass with `out_ready`=0 for 5 cycles after the first `out_valid` → `in_ready` drops after 2 samples are in flight; no read is issued while stalled; outputs stay stable; no pair is lost or duplicated.
- `in_valid` gapped (1 cycle on, 2 off) → `mem_ren` fires only on acceptance; pairs stay in order with correct weights.
- `start` pulsed mid-RUN, and `in_valid` asserted while in IDLE → both are ignored; `in_ready`=0 in IDLE; `cnt` is unaffected.
- `rst` asserted after the 2nd acceptance → all outputs go to their reset values; a new `start` reads from address 0 again.
- `WEIGHT_LOAD_EN` builds: write 0x00AA to address 2 in IDLE, then run a pass → the 3rd pair carries 0x00AA. A write during RUN → `wr_err`=1 for 1 cycle and `mem_wen` stays 0.
